// File: rtl/daisy_readout_sequencer.sv
// Frame scheduler for the FSM_BLOCK daisy chain: SAMP strobe generation, capture of the
// chain-tail words with block/channel tags, and a small valid/ready output FIFO.
module daisy_readout_sequencer #(
  parameter int unsigned BITS_ADC      = 12,
  parameter int unsigned ROW_BLOCK_NUM = 8,
  parameter int unsigned CH_NUM        = 4,
  parameter int unsigned SAMP_W        = 2,
  parameter int unsigned ADC_LAT       = 32,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                             clk_3p2M,
  input  logic                             rst,
  input  logic                             en,
  input  logic [15:0]                      period,
  input  logic                             clr_status,
  input  logic [BITS_ADC:0]                chain_in,
  output logic                             SAMP,
  output logic [BITS_ADC-1:0]              out_data,
  output logic [$clog2(ROW_BLOCK_NUM)-1:0] out_blk,
  output logic [$clog2(CH_NUM)-1:0]        out_ch,
  output logic                             out_sof,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             fifo_ovf,
  output logic                             frame_ovr,
  output logic [7:0]                       err_cnt,
  output logic [15:0]                      frame_cnt
);

  localparam int unsigned N          = ROW_BLOCK_NUM * CH_NUM;
  localparam int unsigned K_W        = $clog2(N);
  localparam int unsigned BLK_W      = $clog2(ROW_BLOCK_NUM);
  localparam int unsigned CH_W       = $clog2(CH_NUM);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam int unsigned TMR_W      = 16;
  localparam int unsigned MIN_PERIOD = SAMP_W + ADC_LAT + N;

  typedef enum logic [2:0] {S_IDLE, S_SAMP, S_LAT, S_READ, S_WAIT} state_t;

  typedef struct packed {
    logic                sof;
    logic [BLK_W-1:0]    blk;
    logic [CH_W-1:0]     ch;
    logic [BITS_ADC-1:0] data;
  } word_t;

  state_t             state;
  logic [TMR_W-1:0]   tmr;
  logic [TMR_W-1:0]   period_l;
  logic [K_W-1:0]     k;
  logic               start_c;
  logic               push_c;
  logic [7:0]         err_base_c;
  word_t              word_c;

  word_t              mem [FIFO_DEPTH];
  word_t              head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt_c;
  logic               pop_c;
  logic               full_c;
  logic               push_ok_c;

  // Frame start, capture strobe and tag of the word currently on the chain tail
  always_comb begin
    start_c = 1'b0;
    case (state)
      S_IDLE:  start_c = en;
      S_WAIT:  start_c = en && (tmr == period_l - TMR_W'(1));
      default: start_c = 1'b0;
    endcase
    push_c      = (state == S_READ);
    err_base_c  = clr_status ? 8'd0 : err_cnt;
    word_c      = '0;
    word_c.sof  = (k == '0);
    word_c.blk  = BLK_W'(32'(k) / CH_NUM);
    word_c.ch   = CH_W'(32'(k) % CH_NUM);
    word_c.data = chain_in[BITS_ADC-1:0];
  end

  // Sequencer; a too-short period is stretched to the minimum frame length
  always_ff @(posedge clk_3p2M) begin
    if (rst) begin
      state     <= S_IDLE;
      tmr       <= '0;
      period_l  <= '0;
      k         <= '0;
      SAMP      <= 1'b0;
      busy      <= 1'b0;
      frame_ovr <= 1'b0;
      err_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      if (clr_status) begin
        frame_ovr <= 1'b0;
        err_cnt   <= '0;
      end
      tmr <= tmr + TMR_W'(1);
      if (start_c) begin
        state     <= S_SAMP;
        SAMP      <= 1'b1;
        busy      <= 1'b1;
        tmr       <= '0;
        frame_cnt <= frame_cnt + 16'd1;
        if (period <= TMR_W'(MIN_PERIOD)) begin
          frame_ovr <= 1'b1;
          period_l  <= TMR_W'(MIN_PERIOD);
        end else begin
          period_l  <= period;
        end
      end else begin
        case (state)
          S_IDLE: tmr <= '0;
          S_SAMP: if (tmr == TMR_W'(SAMP_W - 1)) begin
            state <= S_LAT;
            SAMP  <= 1'b0;
          end
          S_LAT: if (tmr == TMR_W'(ADC_LAT - 1)) begin
            state <= S_READ;
            k     <= '0;
          end
          S_READ: begin
            k <= k + K_W'(1);
            if (chain_in[BITS_ADC])
              err_cnt <= (err_base_c == 8'hFF) ? 8'hFF : err_base_c + 8'd1;
            if (k == K_W'(N - 1)) begin
              state <= en ? S_WAIT : S_IDLE;
              busy  <= en;
            end
          end
          S_WAIT: if (tmr == period_l - TMR_W'(1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            SAMP  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    pop_c     = out_valid & out_ready;
    full_c    = (cnt == CNT_W'(FIFO_DEPTH));
    push_ok_c = push_c & (~full_c | pop_c);
    cnt_nxt_c = cnt + CNT_W'(push_ok_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge clk_3p2M) begin
    if (push_ok_c) mem[wr_ptr] <= word_c;
  end

  // Output FIFO; head register always mirrors the oldest entry so there is no bubble
  always_ff @(posedge clk_3p2M) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      fifo_ovf  <= 1'b0;
      head      <= '0;
    end else begin
      if (clr_status) fifo_ovf <= 1'b0;
      if (push_c && full_c && !pop_c) fifo_ovf <= 1'b1;
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      cnt       <= cnt_nxt_c;
      out_valid <= (cnt_nxt_c != '0);
      if (pop_c) begin
        if (cnt > CNT_W'(1)) head <= mem[rd_ptr + PTR_W'(1)];
        else if (push_ok_c) head <= word_c;
      end else if ((cnt == '0) && push_ok_c) begin
        head <= word_c;
      end
    end
  end

  assign out_data = head.data;
  assign out_blk  = head.blk;
  assign out_ch   = head.ch;
  assign out_sof  = head.sof;

endmodule

// File: tb/tb_daisy_readout_sequencer.sv
// Directed bench for daisy_readout_sequencer; window c is the clock period starting c edges after SAMP rises.
module tb_daisy_readout_sequencer;

  logic        clk_3p2M = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] period = 16'd100;
  logic        clr_status = 1'b0;
  logic [12:0] chain_in = 13'h0;
  logic        SAMP;
  logic [11:0] out_data;
  logic [2:0]  out_blk;
  logic [1:0]  out_ch;
  logic        out_sof;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        fifo_ovf;
  logic        frame_ovr;
  logic [7:0]  err_cnt;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk_3p2M = ~clk_3p2M;

  daisy_readout_sequencer dut (
    .clk_3p2M  (clk_3p2M),
    .rst       (rst),
    .en        (en),
    .period    (period),
    .clr_status(clr_status),
    .chain_in  (chain_in),
    .SAMP      (SAMP),
    .out_data  (out_data),
    .out_blk   (out_blk),
    .out_ch    (out_ch),
    .out_sof   (out_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .fifo_ovf  (fifo_ovf),
    .frame_ovr (frame_ovr),
    .err_cnt   (err_cnt),
    .frame_cnt (frame_cnt)
  );

  // Chain tail content at frame-relative clock rel: word k during the read window, idle fill elsewhere
  function automatic logic [12:0] chain_word(input int rel, input int err_k);
    int k;
    k = rel - 32;
    if (k < 0 || k > 31) return 13'h1FFF;
    if (k == err_k) return 13'h1000 | 13'(k);
    return 13'(k);
  endfunction

  task automatic step();
    @(posedge clk_3p2M);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr_status = 1'b0; out_ready = 1'b0; chain_in = 13'h0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (SAMP !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL reset_ctrl got samp=%b busy=%b valid=%b want 0/0/0", SAMP, busy, out_valid); end
    total++; if (out_data !== 12'h0 || out_blk !== 3'd0 || out_ch !== 2'd0 || out_sof !== 1'b0) begin bad++; $display("FAIL reset_data got %0h/%0d/%0d/%b want 0/0/0/0", out_data, out_blk, out_ch, out_sof); end
    total++; if (fifo_ovf !== 1'b0 || frame_ovr !== 1'b0 || err_cnt !== 8'd0 || frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_status got ovf=%b ovr=%b err=%0d fc=%0d want 0/0/0/0", fifo_ovf, frame_ovr, err_cnt, frame_cnt); end
    run(3);
    total++; if (SAMP !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_idle got samp=%b busy=%b want 0/0", SAMP, busy); end
  endtask

  task automatic test_normal_frame();
    int rel;
    int k;
    do_reset();
    period = 16'd100; out_ready = 1'b1; en = 1'b1;
    step();
    for (int c = 0; c < 102; c++) begin
      rel = c % 100;
      chain_in = chain_word(rel, -1);
      total++; if (SAMP !== (rel < 2)) begin bad++; $display("FAIL normal_samp c=%0d got=%b want=%b", c, SAMP, rel < 2); end
      total++; if (out_valid !== (c >= 33 && c <= 64)) begin bad++; $display("FAIL normal_valid c=%0d got=%b want=%b", c, out_valid, c >= 33 && c <= 64); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL normal_busy c=%0d got=%b want=1", c, busy); end
      total++; if (frame_cnt !== ((c >= 100) ? 16'd2 : 16'd1)) begin bad++; $display("FAIL normal_fcnt c=%0d got=%0d want=%0d", c, frame_cnt, (c >= 100) ? 2 : 1); end
      if (c >= 33 && c <= 64) begin
        k = c - 33;
        total++;
        if (out_data !== 12'(k) || out_blk !== 3'(k / 4) || out_ch !== 2'(k % 4) || out_sof !== (k == 0)) begin
          bad++; $display("FAIL normal_word c=%0d got=%0h/%0d/%0d/%b want=%0h/%0d/%0d/%b", c, out_data, out_blk, out_ch, out_sof, k, k / 4, k % 4, k == 0);
        end
      end
      step();
    end
    en = 1'b0; chain_in = 13'h0;
    run(80);
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL normal_end got busy=%b valid=%b want 0/0", busy, out_valid); end
    total++; if (err_cnt !== 8'd0 || frame_ovr !== 1'b0 || fifo_ovf !== 1'b0 || frame_cnt !== 16'd2) begin bad++; $display("FAIL normal_status got err=%0d ovr=%b ovf=%b fc=%0d want 0/0/0/2", err_cnt, frame_ovr, fifo_ovf, frame_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    period = 16'd100; out_ready = 1'b0; en = 1'b1;
    step();
    en = 1'b0;
    for (int c = 0; c <= 70; c++) begin
      chain_in = chain_word(c, -1);
      if (c == 36) begin total++; if (fifo_ovf !== 1'b0) begin bad++; $display("FAIL bp_ovf_early got=%b want=0", fifo_ovf); end end
      if (c == 37) begin total++; if (fifo_ovf !== 1'b1) begin bad++; $display("FAIL bp_ovf got=%b want=1", fifo_ovf); end end
      if (c == 40 || c == 70) begin
        total++; if (out_valid !== 1'b1 || out_data !== 12'h0 || out_sof !== 1'b1) begin bad++; $display("FAIL bp_hold c=%0d got valid=%b data=%0h sof=%b want 1/0/1", c, out_valid, out_data, out_sof); end
      end
      step();
    end
    total++; if (busy !== 1'b0 || SAMP !== 1'b0 || frame_cnt !== 16'd1) begin bad++; $display("FAIL bp_idle got busy=%b samp=%b fc=%0d want 0/0/1", busy, SAMP, frame_cnt); end
    chain_in = 13'h0; out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 12'(j) || out_blk !== 3'd0 || out_ch !== 2'(j) || out_sof !== (j == 0)) begin
        bad++; $display("FAIL bp_drain j=%0d got v=%b %0h/%0d/%0d/%b want 1 %0h/0/%0d/%b", j, out_valid, out_data, out_blk, out_ch, out_sof, j, j, j == 0);
      end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", out_valid); end
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    total++; if (fifo_ovf !== 1'b0) begin bad++; $display("FAIL bp_clr got=%b want=0", fifo_ovf); end
  endtask

  task automatic test_overrun();
    int rel;
    do_reset();
    period = 16'd40; out_ready = 1'b1; en = 1'b1; chain_in = 13'h0;
    step();
    for (int c = 0; c <= 140; c++) begin
      rel = c % 66;
      clr_status = (c == 65 || c == 70);
      total++; if (SAMP !== (rel < 2)) begin bad++; $display("FAIL ovr_samp c=%0d got=%b want=%b", c, SAMP, rel < 2); end
      if (c == 0 || c == 66 || c == 132) begin
        total++; if (frame_ovr !== 1'b1) begin bad++; $display("FAIL ovr_flag c=%0d got=%b want=1", c, frame_ovr); end
      end
      if (c == 71) begin
        total++; if (frame_ovr !== 1'b0) begin bad++; $display("FAIL ovr_clr got=%b want=0", frame_ovr); end
      end
      if (c == 132) begin
        total++; if (frame_cnt !== 16'd3) begin bad++; $display("FAIL ovr_fcnt got=%0d want=3", frame_cnt); end
      end
      step();
    end
    clr_status = 1'b0; en = 1'b0;
    run(80);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovr_end got busy=%b want=0", busy); end
  endtask

  task automatic test_period_boundary();
    logic exp_samp;
    do_reset();
    period = 16'd67; out_ready = 1'b1; en = 1'b1; chain_in = 13'h0;
    step();
    for (int c = 0; c <= 136; c++) begin
      if (c == 10) period = 16'd66;
      exp_samp = (c < 2) || (c >= 67 && c < 69) || (c >= 133 && c < 135);
      total++; if (SAMP !== exp_samp) begin bad++; $display("FAIL bnd_samp c=%0d got=%b want=%b", c, SAMP, exp_samp); end
      total++; if (frame_ovr !== (c >= 67)) begin bad++; $display("FAIL bnd_ovr c=%0d got=%b want=%b", c, frame_ovr, c >= 67); end
      step();
    end
    en = 1'b0;
    run(80);
    total++; if (busy !== 1'b0 || frame_cnt !== 16'd3) begin bad++; $display("FAIL bnd_end got busy=%b fc=%0d want 0/3", busy, frame_cnt); end
  endtask

  task automatic test_error_word();
    do_reset();
    period = 16'd100; out_ready = 1'b1; en = 1'b1;
    step();
    en = 1'b0;
    for (int c = 0; c <= 70; c++) begin
      chain_in = chain_word(c, 5);
      if (c == 37) begin total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL err_early got=%0d want=0", err_cnt); end end
      if (c == 38) begin
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL err_cnt got=%0d want=1", err_cnt); end
        total++; if (out_valid !== 1'b1 || out_data !== 12'h5 || out_blk !== 3'd1 || out_ch !== 2'd1 || out_sof !== 1'b0) begin bad++; $display("FAIL err_word got v=%b %0h/%0d/%0d/%b want 1 5/1/1/0", out_valid, out_data, out_blk, out_ch, out_sof); end
      end
      step();
    end
    total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL err_hold got=%0d want=1", err_cnt); end
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL err_clr got=%0d want=0", err_cnt); end
  endtask

  task automatic test_err_saturate();
    do_reset();
    period = 16'd40; out_ready = 1'b1; en = 1'b1; chain_in = 13'h1FFF;
    step();
    run(7 * 66);
    total++; if (err_cnt !== 8'd224) begin bad++; $display("FAIL sat_mid got=%0d want=224", err_cnt); end
    en = 1'b0;
    run(80);
    total++; if (err_cnt !== 8'd255 || busy !== 1'b0) begin bad++; $display("FAIL sat_end got err=%0d busy=%b want 255/0", err_cnt, busy); end
    chain_in = 13'h0;
  endtask

  task automatic test_en_drop();
    int words;
    int k;
    words = 0;
    do_reset();
    period = 16'd100; out_ready = 1'b1; en = 1'b1;
    step();
    for (int c = 0; c <= 120; c++) begin
      if (c == 10) en = 1'b0;
      chain_in = chain_word(c, -1);
      if (out_valid === 1'b1) words++;
      total++; if (SAMP !== (c < 2)) begin bad++; $display("FAIL drop_samp c=%0d got=%b want=%b", c, SAMP, c < 2); end
      total++; if (busy !== (c <= 63)) begin bad++; $display("FAIL drop_busy c=%0d got=%b want=%b", c, busy, c <= 63); end
      if (c >= 33 && c <= 64) begin
        k = c - 33;
        total++; if (out_valid !== 1'b1 || out_data !== 12'(k)) begin bad++; $display("FAIL drop_word c=%0d got v=%b %0h want 1 %0h", c, out_valid, out_data, k); end
      end
      step();
    end
    total++; if (words != 32) begin bad++; $display("FAIL drop_count got=%0d want=32", words); end
    total++; if (frame_cnt !== 16'd1 || err_cnt !== 8'd0) begin bad++; $display("FAIL drop_status got fc=%0d err=%0d want 1/0", frame_cnt, err_cnt); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    period = 16'd100; out_ready = 1'b0; en = 1'b1;
    step();
    for (int c = 0; c < 40; c++) begin
      chain_in = chain_word(c, -1);
      step();
    end
    total++; if (out_valid !== 1'b1 || busy !== 1'b1 || frame_cnt !== 16'd1 || fifo_ovf !== 1'b1) begin bad++; $display("FAIL rmid_pre got v=%b busy=%b fc=%0d ovf=%b want 1/1/1/1", out_valid, busy, frame_cnt, fifo_ovf); end
    rst = 1'b1; en = 1'b0;
    step();
    total++; if (out_valid !== 1'b0 || SAMP !== 1'b0 || frame_cnt !== 16'd0 || busy !== 1'b0) begin bad++; $display("FAIL rmid got v=%b samp=%b fc=%0d busy=%b want 0/0/0/0", out_valid, SAMP, frame_cnt, busy); end
    total++; if (fifo_ovf !== 1'b0) begin bad++; $display("FAIL rmid_ovf got=%b want=0", fifo_ovf); end
    rst = 1'b0;
    run(5);
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_after got v=%b busy=%b want 0/0", out_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_backpressure();
    test_overrun();
    test_period_boundary();
    test_error_word();
    test_err_saturate();
    test_en_drop();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
